router_ingress: RTL and testbench

- Packet ingress stage of the 1x3 router; sits directly upstream of the three per-destination router FIFOs.
- Accepts a byte-serial packet from the source (header, payload, parity), decodes the destination and back-pressures the source through busy.
- Writes header, payload and parity into the selected FIFO with the first-byte marker, and checks packet parity.
- Packet format: header[7:2] = payload length L (0..63), header[1:0] = address (0..2 valid, 3 invalid). Followed by L payload bytes and 1 parity byte, where parity = XOR of header and all payload bytes.

---
 rtl/router_ingress_if.sv | 23 ++
 rtl/router_ingress.sv | 140 ++++++++++++++
 tb/tb_router_ingress.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_ingress_if.sv
// rtl/router_ingress_if.sv - source and FIFO-side signal bundle of the router ingress stage
interface router_ingress_if;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic       busy;
   logic [7:0] data_out;
   logic [2:0] write_enb;
   logic       lfd_state;
   logic       err;
   logic       parity_done;

   modport slave (
      input  pkt_valid, data_in, fifo_full, fifo_empty,
      output busy, data_out, write_enb, lfd_state, err, parity_done
   );

   modport master (
      output pkt_valid, data_in, fifo_full, fifo_empty,
      input  busy, data_out, write_enb, lfd_state, err, parity_done
   );
endinterface

// File: rtl/router_ingress.sv
// rtl/router_ingress.sv - 1x3 router ingress: header decode, one-entry skid to the FIFOs, parity check
module router_ingress (
   input  logic            i_clock,
   input  logic            i_reset,
   router_ingress_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DROP    = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [7:0] r_dreg;
   logic       r_dreg_valid;
   logic [1:0] r_addr;
   logic [6:0] r_rem;
   logic [7:0] r_parity;
   logic       r_err;
   logic       r_parity_done;

   logic [1:0] w_hdr_addr;
   logic       w_hdr_fwd;
   logic [3:0] w_full4;
   logic [3:0] w_empty4;
   logic       w_last;
   logic       w_busy;
   logic       w_accept;
   logic       w_lfd;
   logic       w_load;
   logic       w_write;
   logic [2:0] w_write_enb;

   // Address 3 is padded so every 2-bit address indexes a defined flag.
   assign w_hdr_addr = bus.data_in[1:0];
   assign w_hdr_fwd  = (w_hdr_addr != 2'd3);
   assign w_full4    = {1'b0, bus.fifo_full};
   assign w_empty4   = {1'b1, bus.fifo_empty};
   assign w_last     = (r_rem == 7'd1);

   always_comb begin
      w_write_enb = 3'b000;
      for (int i = 0; i < 3; i++) begin
         w_write_enb[i] = r_dreg_valid & (r_addr == i[1:0]) & ~bus.fifo_full[i];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_lfd       = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy   = bus.pkt_valid & (r_dreg_valid | (w_hdr_fwd & ~w_empty4[w_hdr_addr]));
            w_accept = bus.pkt_valid & ~w_busy;
            w_lfd    = w_accept & w_hdr_fwd;
            if (w_accept) begin
               w_state_nxt = w_hdr_fwd ? ST_PAYLOAD : ST_DROP;
            end
         end
         ST_PAYLOAD: begin
            w_busy   = r_dreg_valid & w_full4[r_addr];
            w_accept = bus.pkt_valid & ~w_busy;
            if (w_accept && w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DROP: begin
            w_accept = bus.pkt_valid;
            if (w_accept && w_last) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_load  = w_accept & (((r_state == ST_IDLE) & w_hdr_fwd) | (r_state == ST_PAYLOAD));
   assign w_write = |w_write_enb;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_dreg        <= 8'h00;
         r_dreg_valid  <= 1'b0;
         r_addr        <= 2'd0;
         r_rem         <= 7'd0;
         r_parity      <= 8'h00;
         r_err         <= 1'b0;
         r_parity_done <= 1'b0;
      end else begin
         r_parity_done <= 1'b0;
         // A write and a new load in the same cycle simply replace the byte.
         if (w_load) begin
            r_dreg       <= bus.data_in;
            r_dreg_valid <= 1'b1;
         end else if (w_write) begin
            r_dreg_valid <= 1'b0;
         end
         if (w_accept) begin
            case (r_state)
               ST_IDLE: begin
                  r_addr <= w_hdr_addr;
                  r_rem  <= {1'b0, bus.data_in[7:2]} + 7'd1;
                  r_err  <= 1'b0;
                  if (w_hdr_fwd) begin
                     r_parity <= bus.data_in;
                  end
               end
               ST_PAYLOAD: begin
                  r_rem <= r_rem - 7'd1;
                  if (!w_last) begin
                     r_parity <= r_parity ^ bus.data_in;
                  end else begin
                     r_err         <= (r_parity != bus.data_in);
                     r_parity_done <= 1'b1;
                  end
               end
               default: r_rem <= r_rem - 7'd1;
            endcase
         end
      end
   end

   assign bus.busy        = w_busy;
   assign bus.data_out    = r_dreg;
   assign bus.write_enb   = w_write_enb;
   assign bus.lfd_state   = w_lfd;
   assign bus.err         = r_err;
   assign bus.parity_done = r_parity_done;
endmodule

// File: tb/tb_router_ingress.sv
// tb/tb_router_ingress.sv - directed and randomized bench for router_ingress with a packet-level scoreboard
module tb_router_ingress;
   typedef logic [7:0] pkt_t [8];

   logic clk;
   logic reset;
   router_ingress_if bus();

   router_ingress dut (
      .i_clock (clk),
      .i_reset (reset),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Scoreboard: expected FIFO streams derived from accepted bytes at packet level
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] q2[$];
   logic       exp_err_q[$];
   int         wr_cnt[3];
   logic       prev_lfd;
   logic [2:0] last_wr;
   logic       in_pkt;
   int         m_idx;
   int         m_len;
   logic [1:0] m_addr;
   logic [7:0] m_par;

   initial begin
      for (int i = 0; i < 3; i++) wr_cnt[i] = 0;
      prev_lfd = 1'b0;
      last_wr  = 3'b000;
      in_pkt   = 1'b0;
   end

   always @(negedge clk) begin
      logic [8:0] e;
      logic [7:0] d;
      int         wi;
      int         qsz;
      if (reset) begin
         q0.delete(); q1.delete(); q2.delete(); exp_err_q.delete();
         in_pkt   = 1'b0;
         prev_lfd = 1'b0;
         last_wr  = 3'b000;
      end else begin
         last_wr = bus.write_enb;
         if (bus.write_enb != 3'b000) begin
            check("wr_onehot", 32'($onehot(bus.write_enb)), 1);
            check("wr_into_full", 32'(bus.write_enb & bus.fifo_full), 0);
            wi = bus.write_enb[0] ? 0 : (bus.write_enb[1] ? 1 : 2);
            wr_cnt[wi]++;
            case (wi)
               0: qsz = q0.size();
               1: qsz = q1.size();
               default: qsz = q2.size();
            endcase
            if (qsz == 0) begin
               check("wr_unexpected", 32'(bus.write_enb), 0);
            end else begin
               case (wi)
                  0: e = q0.pop_front();
                  1: e = q1.pop_front();
                  default: e = q2.pop_front();
               endcase
               check("wr_data", 32'(bus.data_out), 32'(e[7:0]));
               check("wr_lfd", 32'(prev_lfd), 32'(e[8]));
            end
         end
         if (bus.parity_done) begin
            if (exp_err_q.size() == 0) check("pd_unexpected", 32'(exp_err_q.size() != 0), 1);
            else check("err_value", 32'(bus.err), 32'(exp_err_q.pop_front()));
         end
         if (bus.pkt_valid && !bus.busy) begin
            d = bus.data_in;
            if (!in_pkt) begin
               in_pkt = 1'b1;
               m_addr = d[1:0];
               m_len  = 32'(d[7:2]);
               m_idx  = 0;
               m_par  = d;
            end else begin
               m_idx++;
               if (m_idx <= m_len) m_par = m_par ^ d;
            end
            case (m_addr)
               2'd0: q0.push_back({m_idx == 0, d});
               2'd1: q1.push_back({m_idx == 0, d});
               2'd2: q2.push_back({m_idx == 0, d});
               default: ;
            endcase
            if (m_idx == m_len + 1) begin
               if (m_addr != 2'd3) exp_err_q.push_back(m_par != d);
               in_pkt = 1'b0;
            end
         end
         prev_lfd = bus.lfd_state;
      end
   end

   // Simple occupancy model of the three FIFOs for the random phase
   localparam int DEPTH = 4;
   logic model_on = 1'b0;
   int   occ[3];

   task automatic tick();
      @(posedge clk);
      #1;
      if (model_on) begin
         for (int i = 0; i < 3; i++) begin
            if (last_wr[i]) occ[i]++;
            if (occ[i] > 0 && $urandom_range(0, 2) == 0) occ[i]--;
            bus.fifo_full[i]  = (occ[i] == DEPTH);
            bus.fifo_empty[i] = (occ[i] == 0);
         end
      end
   endtask

   task automatic run_pkt(input pkt_t p, input int n, input logic [2:0] oh, input logic exp_err);
      for (int k = 0; k <= n; k++) begin
         if (k < n) begin
            bus.pkt_valid = 1'b1;
            bus.data_in   = p[k];
         end else begin
            bus.pkt_valid = 1'b0;
         end
         @(negedge clk);
         if (k < n) check("b2b_busy", 32'(bus.busy), 0);
         check("b2b_lfd", 32'(bus.lfd_state), 32'(k == 0));
         check("b2b_wen", 32'(bus.write_enb), (k >= 1) ? 32'(oh) : 32'(0));
         if (k >= 1) check("b2b_data", 32'(bus.data_out), 32'(p[k-1]));
         check("b2b_pdone", 32'(bus.parity_done), 32'(k == n));
         if (k == n) check("b2b_err", 32'(bus.err), 32'(exp_err));
         else if (k >= 1) check("b2b_err_clear", 32'(bus.err), 0);
         tick();
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      acc = 1'b0;
      while ($urandom_range(0, 3) == 0) begin
         bus.pkt_valid = 1'b0;
         bus.data_in   = 8'($urandom);
         tick();
      end
      bus.pkt_valid = 1'b1;
      bus.data_in   = b;
      for (int w = 0; w < 300 && !acc; w++) begin
         @(negedge clk);
         acc = ~bus.busy;
         tick();
      end
      if (!acc) check("accept_timeout", 32'(acc), 1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      pkt_t       p;
      int         wr_before;
      int         len;
      logic [7:0] hdr;
      logic [7:0] par;
      logic [7:0] b;

      // Reset with a live byte on the input
      reset          = 1'b1;
      bus.pkt_valid  = 1'b1;
      bus.data_in    = 8'hFF;
      bus.fifo_full  = 3'b000;
      bus.fifo_empty = 3'b111;
      tick();
      tick();
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_wen", 32'(bus.write_enb), 0);
      check("rst_data", 32'(bus.data_out), 0);
      check("rst_err", 32'(bus.err), 0);
      check("rst_pdone", 32'(bus.parity_done), 0);
      tick();
      reset         = 1'b0;
      bus.pkt_valid = 1'b0;
      tick();

      // Good packet to FIFO1, back-to-back
      p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00};
      run_pkt(p, 5, 3'b010, 1'b0);

      // Bad parity, err held until next header accepted
      p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'hFF, 8'h00, 8'h00, 8'h00};
      run_pkt(p, 5, 3'b010, 1'b1);
      @(negedge clk);
      check("err_held", 32'(bus.err), 1);
      tick();
      p = '{8'h04, 8'hAA, 8'hAE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_pkt(p, 3, 3'b001, 1'b0);

      // Target FIFO full mid-packet
      wr_before = wr_cnt[1];
      p = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < 3; k++) begin
         bus.pkt_valid = 1'b1;
         bus.data_in   = p[k];
         tick();
      end
      bus.fifo_full = 3'b010;
      bus.data_in   = 8'h33;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("full_busy", 32'(bus.busy), 1);
         check("full_wen", 32'(bus.write_enb), 0);
         check("full_hold", 32'(bus.data_out), 32'h22);
         tick();
      end
      bus.fifo_full = 3'b000;
      @(negedge clk);
      check("full_release", 32'(bus.write_enb), 32'b010);
      tick();
      bus.data_in = 8'h0D;
      tick();
      bus.pkt_valid = 1'b0;
      @(negedge clk);
      check("full_pdone", 32'(bus.parity_done), 1);
      check("full_err", 32'(bus.err), 0);
      tick();
      tick();
      check("full_count", 32'(wr_cnt[1] - wr_before), 5);

      // Header held back while target FIFO is non-empty
      bus.pkt_valid  = 1'b1;
      bus.data_in    = 8'h0E;
      bus.fifo_empty = 3'b011;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("hdr_wait_busy", 32'(bus.busy), 1);
         check("hdr_wait_lfd", 32'(bus.lfd_state), 0);
         tick();
      end
      bus.fifo_empty = 3'b111;
      @(negedge clk);
      check("hdr_go_busy", 32'(bus.busy), 0);
      check("hdr_go_lfd", 32'(bus.lfd_state), 1);
      tick();
      p = '{8'h01, 8'h02, 8'h03, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < 4; k++) begin
         bus.data_in = p[k];
         tick();
      end
      bus.pkt_valid = 1'b0;
      tick();
      tick();

      // Dropped packet (addr 3) followed immediately by a good one
      p = '{8'h0B, 8'h55, 8'h66, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < 4; k++) begin
         bus.pkt_valid = 1'b1;
         bus.data_in   = p[k];
         @(negedge clk);
         check("drop_busy", 32'(bus.busy), 0);
         check("drop_wen", 32'(bus.write_enb), 0);
         check("drop_pdone", 32'(bus.parity_done), 0);
         tick();
      end
      p = '{8'h04, 8'hAA, 8'hAE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      run_pkt(p, 3, 3'b001, 1'b0);
      tick();

      // Randomized packets against live FIFO occupancy
      for (int i = 0; i < 3; i++) occ[i] = 0;
      model_on = 1'b1;
      for (int n = 0; n < 30; n++) begin
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
         hdr = {len[5:0], 2'($urandom_range(0, 3))};
         par = hdr;
         send_byte(hdr);
         for (int j = 0; j < len; j++) begin
            b   = 8'($urandom);
            par = par ^ b;
            send_byte(b);
         end
         if ($urandom_range(0, 4) == 0) par = par ^ 8'($urandom_range(1, 255));
         send_byte(par);
      end
      bus.pkt_valid = 1'b0;
      repeat (80) tick();

      check("drain_q0", q0.size(), 0);
      check("drain_q1", q1.size(), 0);
      check("drain_q2", q2.size(), 0);
      check("drain_err_q", exp_err_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
